// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the gshare branch predictor.
// Latency: n/a (pure functions, no state).
// Backpressure: n/a.
package bp_pkg;

    // Helpers work on fixed maximum widths; callers cast to their parameter widths.
    // IDX_BITS and HIST_BITS are limited to 16 by these widths.
    localparam int unsigned BP_MAX_CTR  = 4;
    localparam int unsigned BP_MAX_IDX  = 16;

    // Weakly-not-taken: 2^(cb-1)-1.
    function automatic logic [BP_MAX_CTR-1:0] ctr_init(input int unsigned cb);
        return 4'((32'd1 << (cb - 1)) - 32'd1);
    endfunction

    // Saturating increment, ceiling 2^cb-1.
    function automatic logic [BP_MAX_CTR-1:0] ctr_inc(input logic [BP_MAX_CTR-1:0] c,
                                                      input int unsigned cb);
        logic [BP_MAX_CTR:0] maxv;
        maxv = 5'((32'd1 << cb) - 32'd1);
        return ({1'b0, c} == maxv) ? c : c + 4'd1;
    endfunction

    // Saturating decrement, floor 0.
    function automatic logic [BP_MAX_CTR-1:0] ctr_dec(input logic [BP_MAX_CTR-1:0] c);
        return (c == 4'd0) ? c : c - 4'd1;
    endfunction

    // gshare index: word-aligned PC bits XOR zero-extended history, masked to ib bits.
    function automatic logic [BP_MAX_IDX-1:0] bp_index(input logic [63:0] pc,
                                                       input logic [BP_MAX_IDX-1:0] hist,
                                                       input int unsigned ib);
        logic [BP_MAX_IDX-1:0] mask;
        mask = 16'((32'd1 << ib) - 32'd1);
        return (pc[BP_MAX_IDX+1:2] ^ hist) & mask;
    endfunction

    // Shift an outcome into the history, keeping hb bits.
    function automatic logic [BP_MAX_IDX-1:0] hist_shift(input logic [BP_MAX_IDX-1:0] h,
                                                         input logic t,
                                                         input int unsigned hb);
        logic [BP_MAX_IDX-1:0] mask;
        mask = 16'((32'd1 << hb) - 32'd1);
        return {h[BP_MAX_IDX-2:0], t} & mask;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// bp_counter_table: 2^IDX_BITS saturating counters, one comb read, one sync train port.
// Latency: read 0 cycles; training lands at the next clock edge.
// Backpressure: none; caller gates wr_en_i.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 7,
    parameter int CTR_BITS = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output logic [CTR_BITS-1:0] rd_ctr_o,
    input  logic                wr_en_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic                wr_taken_i
);
    localparam int DEPTH = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));

    logic [CTR_BITS-1:0] ctr_q [DEPTH];
    logic [CTR_BITS-1:0] wr_cur;
    logic [CTR_BITS-1:0] wr_d;

    assign rd_ctr_o = ctr_q[rd_idx_i];
    assign wr_cur   = ctr_q[wr_idx_i];

    // Next value of the trained entry: the actual outcome alone decides direction.
    always_comb begin
        wr_d = wr_cur;
        if (wr_taken_i) wr_d = CTR_BITS'(ctr_inc(4'(wr_cur), CTR_BITS));
        else            wr_d = CTR_BITS'(ctr_dec(4'(wr_cur)));
    end

    // Counter array: reset every entry to weakly-not-taken, else apply one training write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= wr_d;
        end
    end

endmodule

// File: rtl/bp_gshare.sv
// bp_gshare: gshare predictor (PC ^ speculative history); optional stats under BP_STATS_EN.
// Latency: prediction 0 cycles from registered state; history/training update at next edge.
// Backpressure: rdy_in low freezes all state and forces outputs to 0; callers hold inputs.
module bp_gshare
    import bp_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_BITS   = 7,
    parameter int HIST_BITS  = 4,
    parameter int CTR_BITS   = 2
) (
    input  logic                                      clk_in,
    input  logic                                      rst_in,
    input  logic                                      rdy_in,
    input  logic                                      decoder_bp_en_in,
    input  logic [ADDR_WIDTH-1:0]                     decoder_bp_pc_in,
    input  logic [ADDR_WIDTH-1:0]                     decoder_bp_target_in,
    output logic                                      bp_instqueue_rst_out,
    output logic                                      bp_if_en_out,
    output logic [ADDR_WIDTH-1:0]                     bp_if_pc_out,
    output logic                                      bp_rs_taken_out,
    output logic [((HIST_BITS > 0) ? HIST_BITS : 1)-1:0] bp_rs_hist_out,
`ifdef BP_STATS_EN
    output logic [31:0]                               bp_stat_branches_out,
    output logic [31:0]                               bp_stat_miss_out,
`endif
    input  logic                                      rob_bp_en_in,
    input  logic                                      rob_bp_correct_in,
    input  logic                                      rob_bp_taken_in,
    input  logic [ADDR_WIDTH-1:0]                     rob_bp_pc_in,
    input  logic [((HIST_BITS > 0) ? HIST_BITS : 1)-1:0] rob_bp_hist_in
);
    localparam int HW = (HIST_BITS > 0) ? HIST_BITS : 1;

    logic                active;
    logic                query;
    logic                take;
    logic                pred_taken;
    logic                recover;
    logic [HW-1:0]       ghr;
    logic [IDX_BITS-1:0] q_idx;
    logic [IDX_BITS-1:0] u_idx;
    logic [CTR_BITS-1:0] q_ctr;

    assign active     = rdy_in && !rst_in;
    assign query      = active && decoder_bp_en_in;
    assign recover    = rob_bp_en_in && !rob_bp_correct_in;
    assign q_idx      = IDX_BITS'(bp_index(64'(decoder_bp_pc_in), 16'(ghr), IDX_BITS));
    assign u_idx      = IDX_BITS'(bp_index(64'(rob_bp_pc_in), 16'(rob_bp_hist_in), IDX_BITS));
    assign pred_taken = q_ctr[CTR_BITS-1];
    assign take       = query && pred_taken;

    assign bp_instqueue_rst_out = take;
    assign bp_if_en_out         = take;
    assign bp_rs_taken_out      = take;
    assign bp_if_pc_out         = take  ? decoder_bp_target_in : '0;
    assign bp_rs_hist_out       = query ? ghr : '0;

    bp_counter_table #(
        .IDX_BITS (IDX_BITS),
        .CTR_BITS (CTR_BITS)
    ) u_table (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .rd_idx_i   (q_idx),
        .rd_ctr_o   (q_ctr),
        .wr_en_i    (rdy_in && rob_bp_en_in),
        .wr_idx_i   (u_idx),
        .wr_taken_i (rob_bp_taken_in)
    );

    generate
        if (HIST_BITS > 0) begin : g_ghr
            logic [HIST_BITS-1:0] ghr_q;
            logic [HIST_BITS-1:0] ghr_d;

            // Recovery from the committed snapshot beats the speculative shift of a squashed query.
            always_comb begin
                ghr_d = ghr_q;
                if (recover)
                    ghr_d = HIST_BITS'(hist_shift(16'(rob_bp_hist_in), rob_bp_taken_in, HIST_BITS));
                else if (decoder_bp_en_in)
                    ghr_d = HIST_BITS'(hist_shift(16'(ghr_q), pred_taken, HIST_BITS));
            end

            // History register, frozen while rdy_in is low.
            always_ff @(posedge clk_in) begin
                if (rst_in)      ghr_q <= '0;
                else if (rdy_in) ghr_q <= ghr_d;
            end

            assign ghr = ghr_q;
        end else begin : g_no_ghr
            assign ghr = '0;
        end
    endgenerate

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_miss_q;

    // Saturating commit and misprediction counters.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stat_br_q   <= '0;
            stat_miss_q <= '0;
        end else if (rdy_in && rob_bp_en_in) begin
            if (stat_br_q != 32'hFFFF_FFFF) stat_br_q <= stat_br_q + 32'd1;
            if (!rob_bp_correct_in && stat_miss_q != 32'hFFFF_FFFF)
                stat_miss_q <= stat_miss_q + 32'd1;
        end
    end

    assign bp_stat_branches_out = stat_br_q;
    assign bp_stat_miss_out     = stat_miss_q;
`endif

endmodule

// File: doc/bp_gshare.md
Name: bp_gshare

Overview:
Parametrised branch predictor that supersedes the fixed 128-entry bimodal predictor.
- Holds a table of 2^IDX_BITS saturating counters, CTR_BITS wide, indexed by PC XOR speculative global history (gshare).
- The decoder queries it; on predict-taken it redirects instruction fetch, flushes the instruction queue and tags the dispatched instruction.
- The reorder buffer trains the table at commit and restores the history on a misprediction.

Parameters:
ADDR_WIDTH, 32, PC/target width.
IDX_BITS, 7, log2 of table depth.
HIST_BITS, 4, global history length. Legal range 0..IDX_BITS; 0 gives pure bimodal.
CTR_BITS, 2, counter width. Legal range 1..4.

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; when low, state is frozen and outputs are forced to 0
decoder_bp_en_in  in  1  branch query valid
decoder_bp_pc_in  in  ADDR_WIDTH  branch PC
decoder_bp_target_in  in  ADDR_WIDTH  decoded branch target
bp_instqueue_rst_out  out  1  flush instruction queue (predict-taken)
bp_if_en_out  out  1  fetch redirect valid
bp_if_pc_out  out  ADDR_WIDTH  redirect PC
bp_rs_taken_out  out  1  prediction attached to the dispatched branch
bp_rs_hist_out  out  HIST_BITS  history snapshot used for this query; carried through RS/ROB
rob_bp_en_in  in  1  committed-branch update valid
rob_bp_correct_in  in  1  committed prediction was correct
rob_bp_taken_in  in  1  actual outcome
rob_bp_pc_in  in  ADDR_WIDTH  committed branch PC
rob_bp_hist_in  in  HIST_BITS  snapshot returned from bp_rs_hist_out

Behaviour:
- Reset: synchronous, active-high. Sets every counter to weakly-not-taken, 2^(CTR_BITS-1)-1 (2'b01 at CTR_BITS=2). Clears ghr to 0. While rst_in is high, all outputs are 0.
- Index: idx = (pc[IDX_BITS+1:2]) ^ zero-extended history. Query uses the current ghr; update uses rob_bp_hist_in.
- Prediction is combinational from registered state, with 0-cycle latency. Taken = counter MSB.
- Taken query: bp_if_en_out = bp_instqueue_rst_out = bp_rs_taken_out = 1, and bp_if_pc_out = decoder_bp_target_in.
- Not-taken query or no query: all three flags are 0; bp_if_pc_out is don't-care and is driven 0.
- bp_rs_hist_out = ghr whenever a query is presented.
- Speculative history: on the clock edge after a query, ghr <= {ghr[HIST_BITS-2:0], predicted_taken}. When HIST_BITS=0, no ghr register exists.
- Training on rob_bp_en_in, at the clock edge:
  - taken: counter <= min(counter+1, 2^CTR_BITS-1);
  - not taken: counter <= max(counter-1, 0).
  - rob_bp_correct_in does not affect training; the outcome alone decides.
- Recovery: if rob_bp_en_in and !rob_bp_correct_in, ghr <= {rob_bp_hist_in[HIST_BITS-2:0], rob_bp_taken_in}.
- Simultaneous query and training on the same index: the query sees the pre-update counter; the update lands at the edge.
- Simultaneous query and recovery: recovery wins ghr. The speculative shift is discarded, because the ROB flush squashes the query. The query's combinational outputs are still driven.
- rdy_in low: no counter or ghr change; outputs are 0; pending inputs are ignored. Callers hold them.
- Reset asserted mid-stream overrides all updates in that cycle.
- Wrap-around: PC bits above IDX_BITS+1 alias. This is accepted; no tags are kept.

Optional Feature:
BP_STATS_EN:
- Defined: adds ports bp_stat_branches_out (out, 32) and bp_stat_miss_out (out, 32).
  - Both are cleared on reset.
  - Increment on each rob_bp_en_in, and on each such update with !rob_bp_correct_in, respectively, gated by rdy_in.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package bp_pkg holds:
  - counter-init and saturating-increment/decrement functions, parametrised by CTR_BITS;
  - the index function (pc, hist) -> idx;
  - the history-shift function.
- Sub-module bp_counter_table holds the counter array. It has one combinational read port and one synchronous write port, and does the synchronous reset to the init value.
- The top level holds the ghr, output logic, recovery and stats.

Test Plan:
- Reset with HIST_BITS=0, query pc=0x100 -> all flags 0; after 2 taken updates at pc=0x100, query -> bp_if_en_out=1, bp_if_pc_out=decoder target 0x200.
- Saturation, CTR_BITS=2: 5 taken updates then 1 not-taken -> counter 2'b10, still predicts taken; 3 more not-taken -> 2'b00, floor holds.
- History, HIST_BITS=4, ghr=0: taken-trained query -> ghr=4'b0001 next cycle and bp_rs_hist_out=0 during the query. Misprediction with hist=4'b0101 and taken=0 -> ghr=4'b1010.
- Same-cycle query and update on idx 5 with counter 2'b01 and update taken -> query outputs not-taken; the following query predicts taken.
- rdy_in=0 during query and update -> outputs 0, table and ghr unchanged; mid-stream rst_in -> all counters 2'b01, ghr 0.
- BP_STATS_EN defined: 10 updates, 3 incorrect -> branches=10, miss=3.
